// File: rtl/meas_sequencer.sv
// Measurement sequencer: routes one of NUM_CH waves to the F/T engines, then runs the serial sender.
// Define SEQ_CONTINUOUS_EN to add cmd_cont/stop and continuous relaunch of the latched command.
module meas_sequencer #(
    parameter int  NUM_CH = 4,
    parameter int  TO_W   = 24,
    parameter int  TO_CYC = 10_000_000,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_mode,
    input  logic [CH_W-1:0]   cmd_cha,
    input  logic [CH_W-1:0]   cmd_chb,
`ifdef SEQ_CONTINUOUS_EN
    input  logic              cmd_cont,
    input  logic              stop,
`endif
    input  logic [NUM_CH-1:0] waves,
    output logic              f_wave,
    output logic              t_wave,
    output logic              f_start,
    output logic              t_start,
    output logic              c_start,
    input  logic              f_busy,
    input  logic              t_busy,
    input  logic              c_busy,
    output logic [1:0]        mode,
    output logic [CH_W-1:0]   cur_ch,
    output logic              ready,
    output logic              bad_cmd,
    output logic              timeout_err
);

    localparam logic [1:0]      MODE_PER  = 2'b01;
    localparam logic [1:0]      MODE_DUAL = 2'b10;
    localparam logic [1:0]      MODE_SCAN = 2'b11;
    localparam logic [CH_W:0]   NUM_CH_X  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_RUN      = 3'd2,
        S_SEND     = 3'd3,
        S_SEND_RUN = 3'd4,
        S_NEXT     = 3'd5
    } state_t;

    function automatic logic uses_f(input logic [1:0] m);
        return (m != MODE_PER);
    endfunction

    function automatic logic uses_t(input logic [1:0] m);
        return (m == MODE_PER) || (m == MODE_DUAL);
    endfunction

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_mode, w_mode_nxt;
    // r_cur_ch doubles as the latched channel A; in scan it walks the channels.
    logic [CH_W-1:0] r_cur_ch, w_cur_ch_nxt;
    logic [CH_W-1:0] r_chb, w_chb_nxt;
    logic            r_f_start, w_f_start_nxt;
    logic            r_t_start, w_t_start_nxt;
    logic            r_c_start, w_c_start_nxt;
    logic            r_ready, r_bad, w_bad_nxt;
    logic            r_to_err, w_to_err_nxt;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic            w_launch, w_relaunch, w_cmd_bad, w_t_wave;

`ifdef SEQ_CONTINUOUS_EN
    logic            r_cont, w_cont_nxt;
    assign w_relaunch = r_cont & ~stop;
`else
    assign w_relaunch = 1'b0;
`endif

    assign w_cmd_bad = ({1'b0, cmd_cha} >= NUM_CH_X) ||
                       ((cmd_mode == MODE_DUAL) && ({1'b0, cmd_chb} >= NUM_CH_X));

    // Next-state and next-register values for the whole sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_cur_ch_nxt  = r_cur_ch;
        w_chb_nxt     = r_chb;
        w_f_start_nxt = r_f_start;
        w_t_start_nxt = r_t_start;
        w_c_start_nxt = r_c_start;
        w_to_err_nxt  = r_to_err;
        w_to_cnt_nxt  = r_to_cnt;
        w_bad_nxt     = 1'b0;
        w_launch      = 1'b0;
`ifdef SEQ_CONTINUOUS_EN
        w_cont_nxt    = r_cont;
`endif
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && w_cmd_bad) begin
                    w_bad_nxt = 1'b1;
                end else if (cmd_valid) begin
                    w_mode_nxt   = cmd_mode;
                    w_cur_ch_nxt = (cmd_mode == MODE_SCAN) ? {CH_W{1'b0}} : cmd_cha;
                    w_chb_nxt    = cmd_chb;
                    w_to_err_nxt = 1'b0;
                    w_launch     = 1'b1;
`ifdef SEQ_CONTINUOUS_EN
                    w_cont_nxt   = cmd_cont;
`endif
                end else begin
                    w_bad_nxt = 1'b0;
                end
            end
            S_LAUNCH, S_RUN: begin
                if (r_to_cnt == TO_LAST) begin
                    w_f_start_nxt = 1'b0;
                    w_t_start_nxt = 1'b0;
                    w_to_err_nxt  = 1'b1;
                    w_state_nxt   = (r_mode == MODE_SCAN) ? S_NEXT : S_IDLE;
                end else if (r_state == S_LAUNCH) begin
                    // A start still high means its busy has not been seen yet.
                    w_f_start_nxt = r_f_start & ~f_busy;
                    w_t_start_nxt = r_t_start & ~t_busy;
                    w_state_nxt   = (w_f_start_nxt || w_t_start_nxt) ? S_LAUNCH : S_RUN;
                end else if ((!uses_f(r_mode) || !f_busy) && (!uses_t(r_mode) || !t_busy)) begin
                    w_c_start_nxt = 1'b1;
                    w_state_nxt   = S_SEND;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_SEND: begin
                w_c_start_nxt = r_c_start & ~c_busy;
                w_state_nxt   = c_busy ? S_SEND_RUN : S_SEND;
            end
            S_SEND_RUN: begin
                if (c_busy) begin
                    w_state_nxt = S_SEND_RUN;
                end else if (r_mode == MODE_SCAN) begin
                    w_state_nxt = S_NEXT;
                end else if (w_relaunch) begin
                    w_launch = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_NEXT: begin
                if (r_cur_ch != LAST_CH) begin
                    w_cur_ch_nxt = r_cur_ch + CH_W'(1);
                    w_launch     = 1'b1;
                end else if (w_relaunch) begin
                    w_cur_ch_nxt = {CH_W{1'b0}};
                    w_launch     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_f_start_nxt = 1'b0;
                w_t_start_nxt = 1'b0;
                w_c_start_nxt = 1'b0;
            end
        endcase
        if (w_launch) begin
            w_state_nxt   = S_LAUNCH;
            w_f_start_nxt = uses_f(w_mode_nxt);
            w_t_start_nxt = uses_t(w_mode_nxt);
            w_to_cnt_nxt  = {TO_W{1'b0}};
        end else if ((r_state == S_LAUNCH) || (r_state == S_RUN)) begin
            w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end else begin
            w_to_cnt_nxt = r_to_cnt;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'b00;
            r_cur_ch  <= {CH_W{1'b0}};
            r_chb     <= {CH_W{1'b0}};
            r_f_start <= 1'b0;
            r_t_start <= 1'b0;
            r_c_start <= 1'b0;
            r_ready   <= 1'b1;
            r_bad     <= 1'b0;
            r_to_err  <= 1'b0;
            r_to_cnt  <= {TO_W{1'b0}};
`ifdef SEQ_CONTINUOUS_EN
            r_cont    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_cur_ch  <= w_cur_ch_nxt;
            r_chb     <= w_chb_nxt;
            r_f_start <= w_f_start_nxt;
            r_t_start <= w_t_start_nxt;
            r_c_start <= w_c_start_nxt;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_bad     <= w_bad_nxt;
            r_to_err  <= w_to_err_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
`ifdef SEQ_CONTINUOUS_EN
            r_cont    <= w_cont_nxt;
`endif
        end
    end

    // T-engine wave routing depends on the latched mode.
    always_comb begin
        w_t_wave = 1'b0;
        case (r_mode)
            MODE_PER:  w_t_wave = waves[r_cur_ch];
            MODE_DUAL: w_t_wave = waves[r_chb];
            default:   w_t_wave = 1'b0;
        endcase
    end

    assign f_wave      = waves[r_cur_ch];
    assign t_wave      = w_t_wave;
    assign f_start     = r_f_start;
    assign t_start     = r_t_start;
    assign c_start     = r_c_start;
    assign mode        = r_mode;
    assign cur_ch      = r_cur_ch;
    assign ready       = r_ready;
    assign bad_cmd     = r_bad;
    assign timeout_err = r_to_err;

endmodule

// File: tb/tb_meas_sequencer.sv
// Bench for meas_sequencer: behavioural engines, a send scoreboard keyed on c_start,
// and one task per scenario.
`timescale 1ns/1ps
module tb_meas_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_mode, cmd_cha, cmd_chb;
    logic [3:0] waves;
    logic       f_wave, t_wave, f_start, t_start, c_start;
    logic       f_busy, t_busy, c_busy;
    logic [1:0] mode, cur_ch;
    logic       ready, bad_cmd, timeout_err;

    logic       cmd3_valid;
    logic [1:0] cmd3_mode, cmd3_cha, cmd3_chb;
    logic [2:0] waves3;
    logic       f_wave3, t_wave3, f_start3, t_start3, c_start3;
    logic [1:0] mode3, cur_ch3;
    logic       ready3, bad3, to_err3;

    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] exp_q[$];
    logic       prev_c = 1'b0;

    int f_dly = 3, f_len = 50, t_dly = 3, t_len = 30, c_dly = 2, c_len = 5;
    bit f_hang = 1'b0;

    always #5 clk = ~clk;

    meas_sequencer #(.NUM_CH(4), .TO_W(24), .TO_CYC(100)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
        .cmd_cha(cmd_cha), .cmd_chb(cmd_chb),
`ifdef SEQ_CONTINUOUS_EN
        .cmd_cont(1'b0), .stop(1'b0),
`endif
        .waves(waves), .f_wave(f_wave), .t_wave(t_wave),
        .f_start(f_start), .t_start(t_start), .c_start(c_start),
        .f_busy(f_busy), .t_busy(t_busy), .c_busy(c_busy),
        .mode(mode), .cur_ch(cur_ch), .ready(ready), .bad_cmd(bad_cmd),
        .timeout_err(timeout_err)
    );

    meas_sequencer #(.NUM_CH(3), .TO_W(24), .TO_CYC(100)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd3_valid), .cmd_mode(cmd3_mode),
        .cmd_cha(cmd3_cha), .cmd_chb(cmd3_chb),
`ifdef SEQ_CONTINUOUS_EN
        .cmd_cont(1'b0), .stop(1'b0),
`endif
        .waves(waves3), .f_wave(f_wave3), .t_wave(t_wave3),
        .f_start(f_start3), .t_start(t_start3), .c_start(c_start3),
        .f_busy(1'b0), .t_busy(1'b0), .c_busy(1'b0),
        .mode(mode3), .cur_ch(cur_ch3), .ready(ready3), .bad_cmd(bad3),
        .timeout_err(to_err3)
    );

    // Behavioural engines: busy rises some cycles after start, holds, then falls.
    initial begin
        f_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (f_start === 1'b1) begin
                repeat (f_dly) @(negedge clk);
                f_busy = 1'b1;
                repeat (f_len) @(negedge clk);
                while (f_hang) @(negedge clk);
                f_busy = 1'b0;
            end
        end
    end

    initial begin
        t_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (t_start === 1'b1) begin
                repeat (t_dly) @(negedge clk);
                t_busy = 1'b1;
                repeat (t_len) @(negedge clk);
                t_busy = 1'b0;
            end
        end
    end

    initial begin
        c_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (c_start === 1'b1) begin
                repeat (c_dly) @(negedge clk);
                c_busy = 1'b1;
                repeat (c_len) @(negedge clk);
                c_busy = 1'b0;
            end
        end
    end

    // Scoreboard: each rising c_start must match the next expected {mode, cur_ch}.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (c_start === 1'b1 && prev_c === 1'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL send_unexpected: got mode=%0d ch=%0d, want no send", mode, cur_ch);
                end else if ({mode, cur_ch} !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL send_id: got %0h, want %0h", {mode, cur_ch}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                vectors++;
                if ({f_busy, t_busy} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL send_while_busy: got f/t busy=%b, want 00", {f_busy, t_busy});
                end
            end
            prev_c = c_start;
        end
    end

    task automatic send_cmd(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = m; cmd_cha = a; cmd_chb = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_cha = 2'd0; cmd_chb = 2'd0;
        waves = 4'b0000; cmd3_valid = 1'b0; cmd3_mode = 2'b00; cmd3_cha = 2'd0; cmd3_chb = 2'd0;
        waves3 = 3'b000;
        repeat (3) @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b, want 1", ready); end
        vectors++;
        if ({f_start, t_start, c_start, bad_cmd, timeout_err} !== 5'b00000) begin
            miscompares++;
            $display("FAIL rst_flags: got %b, want 00000", {f_start, t_start, c_start, bad_cmd, timeout_err});
        end
        vectors++;
        if ({mode, cur_ch} !== 4'h0) begin miscompares++; $display("FAIL rst_mode_ch: got %h, want 0", {mode, cur_ch}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_freq;
        bit ok;
        bit found;
        logic prev_fs;
        f_dly = 3; f_len = 50; c_dly = 2; c_len = 5;
        exp_q.push_back({2'b00, 2'd2});
        send_cmd(2'b00, 2'd2, 2'd0);
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL freq_ready_fall: got %b, want 0", ready); end
        vectors++;
        if ({f_start, t_start, mode, cur_ch} !== 6'b10_00_10) begin
            miscompares++;
            $display("FAIL freq_launch: got %b, want 100010", {f_start, t_start, mode, cur_ch});
        end
        prev_fs = f_start;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (f_busy === 1'b1) begin found = 1'b1; break; end
            prev_fs = f_start;
        end
        vectors++;
        if (!found || prev_fs !== 1'b1) begin
            miscompares++;
            $display("FAIL freq_start_hold: got busy_seen=%b start_before=%b, want 1 1", found, prev_fs);
        end
        vectors++;
        if (f_start !== 1'b0) begin miscompares++; $display("FAIL freq_start_drop: got %b, want 0", f_start); end
        @(negedge clk); waves = 4'b0100;
        @(posedge clk); #1;
        vectors++;
        if (f_wave !== 1'b1) begin miscompares++; $display("FAIL freq_fwave_hi: got %b, want 1", f_wave); end
        @(negedge clk); waves = 4'b1011;
        @(posedge clk); #1;
        vectors++;
        if ({f_wave, t_wave} !== 2'b00) begin miscompares++; $display("FAIL freq_waves_lo: got %b, want 00", {f_wave, t_wave}); end
        wait_ready(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL freq_ready_return: got timeout, want ready"); end
        vectors++;
        if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL freq_to_err: got %b, want 0", timeout_err); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL freq_pending: got %0d, want 0", exp_q.size()); end
    endtask

    task automatic test_dual;
        bit ok;
        f_dly = 3; f_len = 10; t_dly = 3; t_len = 30;
        exp_q.push_back({2'b10, 2'd1});
        send_cmd(2'b10, 2'd1, 2'd3);
        vectors++;
        if ({f_start, t_start} !== 2'b11) begin miscompares++; $display("FAIL dual_starts: got %b, want 11", {f_start, t_start}); end
        @(negedge clk); waves = 4'b1000;
        @(posedge clk); #1;
        vectors++;
        if ({f_wave, t_wave} !== 2'b01) begin miscompares++; $display("FAIL dual_waves_a: got %b, want 01", {f_wave, t_wave}); end
        @(negedge clk); waves = 4'b0010;
        @(posedge clk); #1;
        vectors++;
        if ({f_wave, t_wave} !== 2'b10) begin miscompares++; $display("FAIL dual_waves_b: got %b, want 10", {f_wave, t_wave}); end
        wait_ready(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL dual_ready: got timeout, want ready"); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL dual_pending: got %0d, want 0", exp_q.size()); end
    endtask

    task automatic test_scan;
        bit ok;
        bit mode_ok;
        f_dly = 1; f_len = 4; c_dly = 1; c_len = 2;
        for (int c = 0; c < 4; c++) exp_q.push_back({2'b11, 2'(c)});
        send_cmd(2'b11, 2'd2, 2'd0);
        vectors++;
        if (cur_ch !== 2'd0) begin miscompares++; $display("FAIL scan_first_ch: got %0d, want 0", cur_ch); end
        ok = 1'b0;
        mode_ok = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin ok = 1'b1; break; end
            if (mode !== 2'b11) mode_ok = 1'b0;
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL scan_ready: got timeout, want ready"); end
        vectors++;
        if (!mode_ok) begin miscompares++; $display("FAIL scan_mode: got mode change, want 3 throughout"); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL scan_pending: got %0d, want 0", exp_q.size()); end
    endtask

    task automatic test_timeout;
        bit ok;
        int to_k;
        f_dly = 3; f_len = 1; f_hang = 1'b1;
        send_cmd(2'b00, 2'd1, 2'd0);
        to_k = -1;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (timeout_err === 1'b1) begin to_k = k; break; end
        end
        vectors++;
        if (to_k != 100) begin miscompares++; $display("FAIL to_cycle: got %0d, want 100", to_k); end
        vectors++;
        if ({ready, f_start, c_start} !== 3'b100) begin
            miscompares++;
            $display("FAIL to_abort: got %b, want 100", {ready, f_start, c_start});
        end
        f_hang = 1'b0;
        for (int i = 0; i < 10 && f_busy === 1'b1; i++) @(negedge clk);
        t_dly = 2; t_len = 5;
        exp_q.push_back({2'b01, 2'd0});
        send_cmd(2'b01, 2'd0, 2'd3);
        vectors++;
        if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b, want 0", timeout_err); end
        vectors++;
        if ({f_start, t_start} !== 2'b01) begin miscompares++; $display("FAIL per_starts: got %b, want 01", {f_start, t_start}); end
        @(negedge clk); waves = 4'b0001;
        @(posedge clk); #1;
        vectors++;
        if (t_wave !== 1'b1) begin miscompares++; $display("FAIL per_twave_hi: got %b, want 1", t_wave); end
        @(negedge clk); waves = 4'b1110;
        @(posedge clk); #1;
        vectors++;
        if (t_wave !== 1'b0) begin miscompares++; $display("FAIL per_twave_lo: got %b, want 0", t_wave); end
        wait_ready(200, ok);
        vectors++;
        if (!ok || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL per_done: got ready_seen=%b pending=%0d, want 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_bad_cmd;
        @(negedge clk);
        cmd3_valid = 1'b1; cmd3_mode = 2'b00; cmd3_cha = 2'd3; cmd3_chb = 2'd0;
        @(negedge clk);
        cmd3_valid = 1'b0;
        vectors++;
        if ({bad3, ready3} !== 2'b11) begin miscompares++; $display("FAIL bad_cha: got %b, want 11", {bad3, ready3}); end
        @(negedge clk);
        vectors++;
        if ({bad3, ready3} !== 2'b01) begin miscompares++; $display("FAIL bad_pulse_end: got %b, want 01", {bad3, ready3}); end
        cmd3_valid = 1'b1; cmd3_mode = 2'b10; cmd3_cha = 2'd0; cmd3_chb = 2'd3;
        @(negedge clk);
        cmd3_valid = 1'b0;
        vectors++;
        if ({bad3, ready3} !== 2'b11) begin miscompares++; $display("FAIL bad_chb: got %b, want 11", {bad3, ready3}); end
        @(negedge clk);
        cmd3_valid = 1'b1; cmd3_mode = 2'b01; cmd3_cha = 2'd2; cmd3_chb = 2'd3;
        @(negedge clk);
        cmd3_valid = 1'b0;
        vectors++;
        if ({bad3, ready3, cur_ch3} !== 4'b0010) begin
            miscompares++;
            $display("FAIL good_last_ch: got %b, want 0010", {bad3, ready3, cur_ch3});
        end
    endtask

    task automatic test_reset_mid_run;
        bit found;
        f_dly = 1; f_len = 40; c_dly = 1; c_len = 2;
        exp_q.push_back({2'b11, 2'd0});
        exp_q.push_back({2'b11, 2'd1});
        send_cmd(2'b11, 2'd0, 2'd0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (cur_ch === 2'd2 && f_busy === 1'b1 && f_start === 1'b0) begin found = 1'b1; break; end
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL rr_reach_run: got timeout, want ch2 in run"); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({f_start, t_start, c_start} !== 3'b000) begin
            miscompares++;
            $display("FAIL rr_starts: got %b, want 000", {f_start, t_start, c_start});
        end
        vectors++;
        if ({ready, cur_ch, mode} !== 5'b1_00_00) begin
            miscompares++;
            $display("FAIL rr_state: got %b, want 10000", {ready, cur_ch, mode});
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rr_pending: got %0d, want 0", exp_q.size()); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ready, f_start} !== 2'b10) begin miscompares++; $display("FAIL rr_after: got %b, want 10", {ready, f_start}); end
    endtask

    initial begin
        test_reset();
        test_freq();
        test_dual();
        test_scan();
        test_timeout();
        test_bad_cmd();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
Parametrised measurement sequencer for the frequency meter, the successor of the fixed two-input top controller. Accepts a command (mode plus channel pair) and routes one of NUM_CH input waves to the F and T engines. Runs those engines through start/busy handshakes, then triggers the serial transmitter and reports ready. Adds an auto-scan mode over all channels and a per-measurement timeout; the single-command flow is one-shot only.

Parameters:
NUM_CH, 4, number of input wave channels (2..16)
CH_W, $clog2(NUM_CH), channel index width (derived localparam, not overridable)
TO_W, 24, timeout counter width
TO_CYC, 10_000_000, clk cycles allowed from start assertion to engine busy falling

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe, sampled only in IDLE
cmd_mode  in  2  00 freq(chA), 01 period(chA), 10 dual (F on chA, T on chB), 11 scan
cmd_cha  in  CH_W  channel A index
cmd_chb  in  CH_W  channel B index (used only in mode 10)
waves  in  NUM_CH  raw input waves
f_wave  out  1  waves[latched chA] (combinational mux of latched index)
t_wave  out  1  waves[chA] in mode 01, waves[chB] in mode 10, else 0
f_start / t_start / c_start  out  1  engine requests (F, T, serial)
f_busy / t_busy / c_busy  in  1  engine busy flags
mode  out  2  latched command mode, driven to the serial block
cur_ch  out  CH_W  channel currently measured or sent
ready  out  1  high only in IDLE
bad_cmd  out  1  one-cycle pulse on a rejected command
timeout_err  out  1  sticky; cleared on next accepted command

Behaviour:
- Reset (async, any state): state=IDLE; all *_start=0; ready=1; bad_cmd=0; timeout_err=0; mode=0; cur_ch=0; latched chA/chB=0; timeout counter=0.
- States: IDLE, LAUNCH, RUN, SEND, SEND_RUN, NEXT.
- IDLE: on cmd_valid, check channels. If cmd_cha>=NUM_CH, or mode 10 and cmd_chb>=NUM_CH, pulse bad_cmd, stay IDLE. Otherwise latch mode/chA/chB, set cur_ch=chA (0 in scan), clear timeout_err, go to LAUNCH next cycle. ready falls the cycle after acceptance.
- LAUNCH: assert the required start (F for 00/11, T for 01, both for 10) and hold each level-high until its busy is seen high. Drop each start the cycle after its busy=1. Go to RUN once all required busies have been seen.
- RUN: wait until all required busies are low, then go to SEND.
- Timeout counter clears on LAUNCH entry and counts each cycle in LAUNCH/RUN. At TO_CYC: drop all starts, set timeout_err, skip SEND. Scan mode goes to NEXT; other modes go to IDLE.
- SEND/SEND_RUN: same level-held handshake on c_start/c_busy; no timeout. On c_busy falling, scan mode goes to NEXT, other modes go to IDLE.
- NEXT: if cur_ch==NUM_CH-1, go to IDLE; else cur_ch+1 and go to LAUNCH.
- Busy already high at LAUNCH entry counts as an immediate acknowledge.
- A busy that drops without ever being seen high is not an ack. It is caught only by the timeout.
- cmd_valid outside IDLE is ignored, with no bad_cmd.
- Starts are never asserted in IDLE.

Optional Feature:
SEQ_CONTINUOUS_EN:
- Defined: adds inputs cmd_cont (latched with the command) and stop (level).
- With cmd_cont=1, completion of SEND (or of NEXT wrap in scan, cur_ch back to 0) relaunches the same command instead of going to IDLE.
- stop=1 is sampled at each completion point and returns to IDLE.
- Not defined: the ports are absent and every command is one-shot.

Test Plan:
- Mode 00, cha=2, f_busy high 3 cycles after f_start for 50 cycles -> f_wave tracks waves[2]; f_start drops the cycle after busy; c_start handshake follows; ready returns; timeout_err=0.
- Mode 10, cha=1, chb=3, t_busy falls 20 cycles after f_busy -> both starts asserted the same cycle; SEND starts only after t_busy falls; t_wave=waves[3].
- Mode 11, NUM_CH=4 -> four LAUNCH/SEND pairs with cur_ch 0,1,2,3, then IDLE; mode=11 throughout.
- TO_CYC=100, f_busy held high forever in mode 00 -> timeout_err=1 at cycle 100 after LAUNCH entry; no c_start; IDLE. A subsequent good command clears timeout_err.
- NUM_CH=3, cmd_cha=3 -> bad_cmd pulses once; state stays IDLE; ready stays 1.
- rst_n pulsed low mid-RUN in scan -> all starts 0, ready=1, and cur_ch=0 asynchronously.
